// File: rtl/slc3_control_if.sv
// Control/datapath bundle for the SLC-3 controller: datapath status in, loads/gates/selects/strobes out.
// master = controller side, slave = datapath side.
interface slc3_control_if;
    logic       Run, Continue;
    logic [3:0] Opcode;
    logic       IR_5, IR_11, BEN;
    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic       GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
    logic       Mem_OE, Mem_WE;

    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
               Mem_OE, Mem_WE
    );
    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
               GatePC, GateMDR, GateALU, GateMARMUX,
               PCMUX, ADDR2MUX, ALUK, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN,
               Mem_OE, Mem_WE
    );
endinterface

// File: rtl/slc3_control.sv
// SLC-3 Moore control FSM: fetch/decode/execute for ADD/AND/NOT/BR/JMP/JSR/LDR/STR.
// Optional pause instruction (opcode 1101) enabled by defining SLC3_PAUSE_EN.
module slc3_control #(
    parameter int MEM_WAIT = 2
) (
    input logic           clk,
    input logic           reset,
    slc3_control_if.master bus
);
    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32,
        S_ADD, S_AND, S_NOT, S22, S12,
        S4, S21, S20, S6, S25, S27, S7, S23, S16,
        PAUSE1, PAUSE2
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

    state_t     state, nxt;
    logic [2:0] wait_cnt;
    logic       in_mem, mem_last;

    assign in_mem   = (state == S33) || (state == S25) || (state == S16);
    assign mem_last = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= HALTED;
            wait_cnt <= '0;
        end else begin
            state    <= nxt;
            wait_cnt <= (in_mem && !mem_last) ? wait_cnt + 3'd1 : 3'd0;
        end
    end

    always_comb begin
        nxt            = state;
        bus.LD_MAR     = 1'b0;
        bus.LD_MDR     = 1'b0;
        bus.LD_IR      = 1'b0;
        bus.LD_BEN     = 1'b0;
        bus.LD_CC      = 1'b0;
        bus.LD_REG     = 1'b0;
        bus.LD_PC      = 1'b0;
        bus.LD_LED     = 1'b0;
        bus.GatePC     = 1'b0;
        bus.GateMDR    = 1'b0;
        bus.GateALU    = 1'b0;
        bus.GateMARMUX = 1'b0;
        bus.PCMUX      = 2'b00;
        bus.ADDR2MUX   = 2'b00;
        bus.ALUK       = 2'b00;
        bus.DRMUX      = 1'b0;
        bus.SR1MUX     = 1'b0;
        bus.SR2MUX     = 1'b0;
        bus.ADDR1MUX   = 1'b0;
        bus.MIO_EN     = 1'b0;
        bus.Mem_OE     = 1'b0;
        bus.Mem_WE     = 1'b0;

        unique case (state)
            HALTED: if (bus.Run) nxt = S18;
            S18: begin
                bus.GatePC = 1'b1;
                bus.LD_MAR = 1'b1;
                bus.LD_PC  = 1'b1;
                nxt        = S33;
            end
            // S33 (fetch) and S25 (LDR) are the same read access; only the exit differs
            S33, S25: begin
                bus.Mem_OE = 1'b1;
                bus.MIO_EN = 1'b1;
                bus.LD_MDR = mem_last;
                if (mem_last) nxt = (state == S33) ? S35 : S27;
            end
            S35: begin
                bus.GateMDR = 1'b1;
                bus.LD_IR   = 1'b1;
                nxt         = S32;
            end
            S32: begin
                bus.LD_BEN = 1'b1;
                case (bus.Opcode)
                    4'b0001: nxt = S_ADD;
                    4'b0101: nxt = S_AND;
                    4'b1001: nxt = S_NOT;
                    4'b0000: nxt = bus.BEN ? S22 : S18;
                    4'b1100: nxt = S12;
                    4'b0100: nxt = S4;
                    4'b0110: nxt = S6;
                    4'b0111: nxt = S7;
`ifdef SLC3_PAUSE_EN
                    4'b1101: nxt = PAUSE1;
`endif
                    default: nxt = S18;
                endcase
            end
            S_ADD, S_AND, S_NOT: begin
                bus.GateALU = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                bus.SR2MUX  = bus.IR_5;
                bus.ALUK    = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b10;
                nxt         = S18;
            end
            S22: begin
                bus.LD_PC    = 1'b1;
                bus.PCMUX    = 2'b10;
                bus.ADDR2MUX = 2'b10;
                nxt          = S18;
            end
            // JMP and JSR-register share the BaseR + 0 target path
            S12, S20: begin
                bus.LD_PC    = 1'b1;
                bus.PCMUX    = 2'b10;
                bus.ADDR1MUX = 1'b1;
                nxt          = S18;
            end
            S4: begin
                bus.GatePC = 1'b1;
                bus.LD_REG = 1'b1;
                bus.DRMUX  = 1'b1;
                nxt        = bus.IR_11 ? S21 : S20;
            end
            S21: begin
                bus.LD_PC    = 1'b1;
                bus.PCMUX    = 2'b10;
                bus.ADDR2MUX = 2'b11;
                nxt          = S18;
            end
            S6, S7: begin
                bus.GateMARMUX = 1'b1;
                bus.LD_MAR     = 1'b1;
                bus.ADDR2MUX   = 2'b01;
                nxt            = (state == S6) ? S25 : S23;
            end
            S27: begin
                bus.GateMDR = 1'b1;
                bus.LD_REG  = 1'b1;
                bus.LD_CC   = 1'b1;
                nxt         = S18;
            end
            S23: begin
                bus.ALUK    = 2'b11;
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                nxt         = S16;
            end
            S16: begin
                bus.Mem_WE = 1'b1;
                if (mem_last) nxt = S18;
            end
`ifdef SLC3_PAUSE_EN
            PAUSE1: begin
                bus.LD_LED = 1'b1;
                if (bus.Continue) nxt = PAUSE2;
            end
            PAUSE2: if (!bus.Continue) nxt = S18;
`endif
            default: nxt = HALTED;
        endcase
    end
endmodule

// File: tb/tb_slc3_control.sv
// Directed bench for slc3_control: MEM_WAIT=2 instance for fetch/execute paths,
// MEM_WAIT=3 instance for the store write window and mid-write reset.
module tb_slc3_control;
    typedef struct packed {
        logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
        logic GatePC, GateMDR, GateALU, GateMARMUX;
        logic [1:0] PCMUX, ADDR2MUX;
        logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
        logic [1:0] ALUK;
        logic Mem_OE, Mem_WE;
    } ctl_t;

    logic clk = 1'b0;
    logic rst2, rst3;
    logic run, cont, ir5, ir11, ben;
    logic [3:0] opc;
    int total = 0, passed = 0;
    bit sel = 1'b0;
    ctl_t o2, o3;

    slc3_control_if i2 ();
    slc3_control_if i3 ();

    slc3_control #(.MEM_WAIT(2)) dut2 (.clk(clk), .reset(rst2), .bus(i2.master));
    slc3_control #(.MEM_WAIT(3)) dut3 (.clk(clk), .reset(rst3), .bus(i3.master));

    always #5 clk = ~clk;

    assign i2.Run = run;  assign i2.Continue = cont; assign i2.Opcode = opc;
    assign i2.IR_5 = ir5; assign i2.IR_11 = ir11;    assign i2.BEN = ben;
    assign i3.Run = run;  assign i3.Continue = cont; assign i3.Opcode = opc;
    assign i3.IR_5 = ir5; assign i3.IR_11 = ir11;    assign i3.BEN = ben;

    assign o2 = {i2.LD_MAR, i2.LD_MDR, i2.LD_IR, i2.LD_BEN, i2.LD_CC, i2.LD_REG, i2.LD_PC, i2.LD_LED,
                 i2.GatePC, i2.GateMDR, i2.GateALU, i2.GateMARMUX, i2.PCMUX, i2.ADDR2MUX,
                 i2.DRMUX, i2.SR1MUX, i2.SR2MUX, i2.ADDR1MUX, i2.MIO_EN, i2.ALUK, i2.Mem_OE, i2.Mem_WE};
    assign o3 = {i3.LD_MAR, i3.LD_MDR, i3.LD_IR, i3.LD_BEN, i3.LD_CC, i3.LD_REG, i3.LD_PC, i3.LD_LED,
                 i3.GatePC, i3.GateMDR, i3.GateALU, i3.GateMARMUX, i3.PCMUX, i3.ADDR2MUX,
                 i3.DRMUX, i3.SR1MUX, i3.SR2MUX, i3.ADDR1MUX, i3.MIO_EN, i3.ALUK, i3.Mem_OE, i3.Mem_WE};

    function automatic ctl_t ex_s18();
        ctl_t e = '0; e.GatePC = 1; e.LD_MAR = 1; e.LD_PC = 1; return e;
    endfunction
    function automatic ctl_t ex_rd(input bit last);
        ctl_t e = '0; e.Mem_OE = 1; e.MIO_EN = 1; e.LD_MDR = last; return e;
    endfunction
    function automatic ctl_t ex_s35();
        ctl_t e = '0; e.GateMDR = 1; e.LD_IR = 1; return e;
    endfunction
    function automatic ctl_t ex_s32();
        ctl_t e = '0; e.LD_BEN = 1; return e;
    endfunction
    function automatic ctl_t ex_alu(input logic [1:0] k, input logic sr2);
        ctl_t e = '0; e.GateALU = 1; e.LD_REG = 1; e.LD_CC = 1; e.ALUK = k; e.SR2MUX = sr2; return e;
    endfunction
    function automatic ctl_t ex_pc(input logic a1, input logic [1:0] a2);
        ctl_t e = '0; e.LD_PC = 1; e.PCMUX = 2'b10; e.ADDR1MUX = a1; e.ADDR2MUX = a2; return e;
    endfunction
    function automatic ctl_t ex_mar();
        ctl_t e = '0; e.GateMARMUX = 1; e.LD_MAR = 1; e.ADDR2MUX = 2'b01; return e;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input ctl_t exp);
        ctl_t got;
        got = sel ? o3 : o2;
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // Starts in S18, checks through S32, leaves the bench at the cycle after dispatch.
    task automatic fetch(input int mw);
        chk("s18", ex_s18());
        for (int i = 0; i < mw; i++) begin
            step(); chk("s33", ex_rd(i == mw - 1));
        end
        step(); chk("s35", ex_s35());
        step(); chk("s32", ex_s32());
        step();
    endtask

    initial begin
        ctl_t z, e;
        z = '0;
        rst2 = 0; rst3 = 0; run = 0; cont = 0; ir5 = 0; ir11 = 0; ben = 0; opc = 4'h0;
        step(); chk("reset_zero", z);
        #3 rst2 = 1;
        step(); step(); chk("halted_no_run", z);

        // Run pulse -> S18, then ADD with immediate
        opc = 4'b0001; ir5 = 1; run = 1;
        step(); run = 0;
        fetch(2); chk("add", ex_alu(2'b00, 1'b1));
        step();

        // Run held high across AND and NOT must not disturb sequencing
        run = 1; opc = 4'b0101; ir5 = 0;
        fetch(2); chk("and", ex_alu(2'b01, 1'b0));
        step();
        opc = 4'b1001;
        fetch(2); chk("not", ex_alu(2'b10, 1'b0));
        step(); run = 0;

        opc = 4'b0000; ben = 0;
        fetch(2); chk("br_not_taken", ex_s18());
        ben = 1;
        fetch(2); chk("br_taken", ex_pc(1'b0, 2'b10));
        step(); chk("br_after", ex_s18());

        opc = 4'b1100;
        fetch(2); chk("jmp", ex_pc(1'b1, 2'b00));
        step();

        opc = 4'b0100; ir11 = 1;
        e = '0; e.GatePC = 1; e.LD_REG = 1; e.DRMUX = 1;
        fetch(2); chk("jsr_r7", e);
        step(); chk("jsr_off11", ex_pc(1'b0, 2'b11));
        step();
        ir11 = 0;
        fetch(2); chk("jsrr_r7", e);
        step(); chk("jsrr_base", ex_pc(1'b1, 2'b00));
        step();

        opc = 4'b0110;
        fetch(2); chk("ldr_mar", ex_mar());
        step(); chk("ldr_rd0", ex_rd(1'b0));
        step(); chk("ldr_rd1", ex_rd(1'b1));
        e = '0; e.GateMDR = 1; e.LD_REG = 1; e.LD_CC = 1;
        step(); chk("ldr_wb", e);
        step();

        opc = 4'b0011;
        fetch(2); chk("unimpl", ex_s18());

        opc = 4'b1101;
        fetch(2);
`ifdef SLC3_PAUSE_EN
        e = '0; e.LD_LED = 1;
        chk("pause1", e);
        step(); chk("pause1_stall", e);
        cont = 1;
        step(); chk("pause2", z);
        step(); chk("pause2_stall", z);
        cont = 0;
        step(); chk("pause_exit", ex_s18());
`else
        chk("pause_off", ex_s18());
`endif

        // Store on the MEM_WAIT=3 instance
        sel = 1; rst3 = 1; opc = 4'b0111;
        step(); chk("dut3_halted", z);
        run = 1; step(); run = 0;
        fetch(3); chk("str_mar", ex_mar());
        e = '0; e.ALUK = 2'b11; e.GateALU = 1; e.LD_MDR = 1;
        step(); chk("str_mdr", e);
        e = '0; e.Mem_WE = 1;
        for (int i = 0; i < 3; i++) begin
            step(); chk("str_we", e);
        end
        step(); chk("str_done", ex_s18());

        // Second store, reset asserted during the second write cycle
        fetch(3); chk("str2_mar", ex_mar());
        step(); step(); chk("str2_we1", e);
        step(); chk("str2_we2", e);
        #2 rst3 = 0;
        #1 chk("str2_rst_now", z);
        step(); chk("str2_rst_hold", z);
        #3 rst3 = 1;
        step(); step(); chk("str2_stay_halted", z);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/slc3_control.md
SLC3_CONTROL -- requirements
Module: slc3_control

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, number of cycles Mem_OE/Mem_WE held per memory access (legal range 1-7).
REQ-002 SHALL have clk, input, 1: single clock; every state update on its rising edge.
REQ-003 SHALL have reset, input, 1: asynchronous, active-low.
REQ-004 SHALL have Run and Continue, input, 1 each: start pulse and resume-from-pause pulse.
REQ-005 SHALL have Opcode, input, 4: IR[15:12].
REQ-006 SHALL have IR_5, IR_11 and BEN, input, 1 each: immediate select, JSR mode and branch-enable from the datapath.
REQ-007 SHALL have LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC and LD_LED, output, 1 each: datapath register loads.
REQ-008 SHALL have GatePC, GateMDR, GateALU and GateMARMUX, output, 1 each: bus drivers.
REQ-009 SHALL have PCMUX and ADDR2MUX, output, 2 each; DRMUX, SR1MUX, SR2MUX, ADDR1MUX and MIO_EN, output, 1 each: mux selects.
REQ-010 SHALL have ALUK, output, 2: 00 ADD, 01 AND, 10 NOT, 11 PASSA.
REQ-011 SHALL have Mem_OE and Mem_WE, output, 1 each: active-high memory strobes.

Function
REQ-012 SHALL be a Moore FSM; all outputs are a decode of the current state only and are 0 in any state not listed as asserting them.
REQ-013 SHALL hold in HALTED until Run=1, then enter S18 on the next edge; Run outside HALTED SHALL be ignored.
REQ-014 S18 SHALL assert GatePC, LD_MAR, LD_PC and PCMUX=00 (PC+1), then go to S33.
REQ-015 S33 SHALL last exactly MEM_WAIT cycles using a 3-bit wait counter, with Mem_OE=1 and MIO_EN=1 throughout and LD_MDR=1 only in the final cycle, then go to S35.
REQ-016 S35 SHALL assert GateMDR and LD_IR, then go to S32; S32 SHALL assert LD_BEN and dispatch on Opcode.
REQ-017 The fetch-to-dispatch latency SHALL be MEM_WAIT+3 cycles, from entry into S18 to the first execute state.
REQ-018 ADD (0001), AND (0101) and NOT (1001) SHALL each take one state: GateALU, LD_REG and LD_CC asserted, ALUK per opcode, and SR2MUX=IR_5. Next state SHALL be S18.
REQ-019 BR (0000) SHALL go to S22 when BEN=1, asserting LD_PC, PCMUX=10, ADDR1MUX=0 and ADDR2MUX=10; when BEN=0 it SHALL go to S18.
REQ-020 JMP (1100) SHALL assert LD_PC, PCMUX=10, ADDR1MUX=1 and ADDR2MUX=00 for one state.
REQ-021 JSR (0100) SHALL first perform R7<-PC (GatePC, LD_REG, DRMUX=1). It SHALL then load PC from PC+off11 when IR_11=1 (ADDR2MUX=11), or from BaseR when IR_11=0.
REQ-022 LDR (0110) SHALL sequence address-to-MAR (GateMARMUX, LD_MAR, ADDR2MUX=01), then a memory read identical to S33, then MDR-to-reg (GateMDR, LD_REG, LD_CC).
REQ-023 STR (0111) SHALL sequence address-to-MAR, then SR-to-MDR (ALUK=11, GateALU, LD_MDR, MIO_EN=0), then MEM_WAIT cycles with Mem_WE=1.
REQ-024 Unimplemented opcodes SHALL return to S18 with no register load.
REQ-025 Memory strobes SHALL never be asserted in the same cycle as LD_PC or LD_REG.

Reset
REQ-026 reset=0 SHALL force HALTED, clear the wait counter and deassert every output immediately, including mid-access Mem_WE.
REQ-027 After reset release, the block SHALL remain in HALTED until the first Run edge.

Configuration
REQ-028 With SLC3_PAUSE_EN defined, opcode 1101 SHALL enter PAUSE1 (LD_LED=1), wait for Continue=1, then PAUSE2, wait for Continue=0, then go to S18.
REQ-029 Without SLC3_PAUSE_EN, opcode 1101 SHALL behave per REQ-024, LD_LED SHALL be constant 0, and Continue SHALL be unused.

Verification
REQ-030 Reset, then Run pulse with MEM_WAIT=2 -> S18 on cycle 1, Mem_OE high on cycles 2-3, LD_MDR only on cycle 3, LD_IR on cycle 4.
REQ-031 Opcode=0001, IR_5=1 -> single execute cycle with ALUK=00, SR2MUX=1, LD_REG=LD_CC=1, then GatePC=1 on the next cycle.
REQ-032 Opcode=0000 with BEN=0 -> no LD_PC after S32; with BEN=1 -> exactly one LD_PC with PCMUX=10.
REQ-033 Opcode=0111 with MEM_WAIT=3 -> Mem_WE high for exactly 3 cycles; reset=0 in the 2nd of them -> Mem_WE low the same cycle and state HALTED.
REQ-034 Opcode=1101 with SLC3_PAUSE_EN -> LD_LED=1 and stall while Continue=0; Continue 1 then 0 -> S18. Without the macro -> direct return to S18.
REQ-035 Run=1 held during execution -> no re-entry to HALTED or S18 beyond the normal sequence.
